// File: rtl/comparator_sweep_driver.sv
// Self-test initiator for a 3-bit comparator: sweeps all 64 operand pairs,
// samples G/E/L after a settle interval and tallies correct and wrong results.
module comparator_sweep_driver #(
    parameter int SETTLE_CYCLES = 1,  // legal range 1..15
    parameter int CNT_W         = 7   // must hold the value 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    output logic             a0,
    output logic             a1,
    output logic             a2,
    output logic             b0,
    output logic             b1,
    output logic             b2,
    output logic             S,
    input  logic             G,
    input  logic             E,
    input  logic             L,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [CNT_W-1:0] lt_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err_flag,
    output logic [5:0]       first_err_idx
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [5:0]       IDX_LAST    = 6'd63;

    state_t           r_state;
    logic [5:0]       r_idx;
    logic [3:0]       r_settle;
    logic [2:0]       r_a;
    logic [2:0]       r_b;
    logic             r_s;
    logic             r_busy;
    logic             r_done;
    logic [CNT_W-1:0] r_gt_cnt;
    logic [CNT_W-1:0] r_eq_cnt;
    logic [CNT_W-1:0] r_lt_cnt;
    logic [CNT_W-1:0] r_err_cnt;
    logic             r_err_flag;
    logic [5:0]       r_first_err_idx;

    logic       w_exp_gt;
    logic       w_exp_eq;
    logic       w_exp_lt;
    logic [2:0] w_exp;
    logic [2:0] w_obs;
    logic       w_ok;
    logic [5:0] w_idx_next;

    // Reference result for the pair currently on the operand lines.
    always_comb begin
        w_exp_eq = (r_a == r_b);
        if (r_s) begin
            w_exp_gt = ($signed(r_a) > $signed(r_b));
        end else begin
            w_exp_gt = (r_a > r_b);
        end
        w_exp_lt = !w_exp_gt && !w_exp_eq;
        w_exp    = {w_exp_gt, w_exp_eq, w_exp_lt};
        w_obs    = {G, E, L};
        // w_exp is always one-hot, so equality also rules out non-one-hot results.
        w_ok       = (w_obs == w_exp);
        w_idx_next = r_idx + 6'd1;
    end

    // NOTE: every register here is assigned with <= so all state advances together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_idx           <= '0;
            r_settle        <= '0;
            r_a             <= '0;
            r_b             <= '0;
            r_s             <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_gt_cnt        <= '0;
            r_eq_cnt        <= '0;
            r_lt_cnt        <= '0;
            r_err_cnt       <= '0;
            r_err_flag      <= 1'b0;
            r_first_err_idx <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state         <= ST_DRIVE;
                        r_s             <= mode;
                        r_idx           <= '0;
                        r_settle        <= '0;
                        r_a             <= '0;
                        r_b             <= '0;
                        r_busy          <= 1'b1;
                        r_done          <= 1'b0;
                        r_gt_cnt        <= '0;
                        r_eq_cnt        <= '0;
                        r_lt_cnt        <= '0;
                        r_err_cnt       <= '0;
                        r_err_flag      <= 1'b0;
                        r_first_err_idx <= '0;
                    end
                end

                ST_DRIVE: begin
                    if (r_settle == SETTLE_LAST) begin
                        r_settle <= '0;
                        r_state  <= ST_SAMPLE;
                    end else begin
                        r_settle <= r_settle + 4'd1;
                    end
                end

                ST_SAMPLE: begin
                    if (w_ok) begin
                        if (w_exp_gt) begin
                            r_gt_cnt <= r_gt_cnt + CNT_ONE;
                        end else if (w_exp_eq) begin
                            r_eq_cnt <= r_eq_cnt + CNT_ONE;
                        end else begin
                            r_lt_cnt <= r_lt_cnt + CNT_ONE;
                        end
                    end else begin
                        r_err_cnt <= r_err_cnt + CNT_ONE;
                        if (!r_err_flag) begin
                            r_err_flag      <= 1'b1;
                            r_first_err_idx <= r_idx;
                        end
                    end

                    // Operands for the next pair are loaded with the index so they are valid throughout DRIVE.
                    if (r_idx == IDX_LAST) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_idx   <= w_idx_next;
                        r_a     <= w_idx_next[5:3];
                        r_b     <= w_idx_next[2:0];
                        r_state <= ST_DRIVE;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign {a2, a1, a0}  = r_a;
    assign {b2, b1, b0}  = r_b;
    assign S             = r_s;
    assign busy          = r_busy;
    assign done          = r_done;
    assign gt_cnt        = r_gt_cnt;
    assign eq_cnt        = r_eq_cnt;
    assign lt_cnt        = r_lt_cnt;
    assign err_cnt       = r_err_cnt;
    assign err_flag      = r_err_flag;
    assign first_err_idx = r_first_err_idx;

endmodule

// File: tb/tb_comparator_sweep_driver.sv
// Bench for comparator_sweep_driver: a bench-side comparator (correct or faulty)
// answers the DUT, and a sweep-level model predicts every output on each cycle.
module tb_comparator_sweep_driver;

    localparam int SETTLE = 1;
    localparam int CNT_W  = 7;
    localparam int LAST_T = 64 * (SETTLE + 1);

    localparam int FLT_NONE     = 0;
    localparam int FLT_IGNORE_S = 1;
    localparam int FLT_GE_STUCK = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic mode = 1'b0;
    logic a0, a1, a2, b0, b1, b2, S;
    logic G, E, L;
    logic busy, done, err_flag;
    logic [CNT_W-1:0] gt_cnt, eq_cnt, lt_cnt, err_cnt;
    logic [5:0] first_err_idx;

    int fault = FLT_NONE;
    int checks = 0;
    int failures = 0;

    comparator_sweep_driver #(.SETTLE_CYCLES(SETTLE), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .a0(a0), .a1(a1), .a2(a2), .b0(b0), .b1(b1), .b2(b2), .S(S),
        .G(G), .E(E), .L(L),
        .busy(busy), .done(done),
        .gt_cnt(gt_cnt), .eq_cnt(eq_cnt), .lt_cnt(lt_cnt), .err_cnt(err_cnt),
        .err_flag(err_flag), .first_err_idx(first_err_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int as_int(input logic [2:0] v, input logic s);
        int r;
        r = int'(v);
        if (s && v[2]) r = r - 8;
        return r;
    endfunction

    function automatic logic [2:0] ref_gel(input logic [2:0] a, input logic [2:0] b, input logic s);
        int ai, bi;
        ai = as_int(a, s);
        bi = as_int(b, s);
        if (ai > bi) return 3'b100;
        if (ai == bi) return 3'b010;
        return 3'b001;
    endfunction

    // The comparator under test, with optional planted faults.
    function automatic logic [2:0] cmp_out(input logic [2:0] a, input logic [2:0] b, input logic s, input int flt);
        case (flt)
            FLT_IGNORE_S: return ref_gel(a, b, 1'b0);
            FLT_GE_STUCK: return 3'b110;
            default:      return ref_gel(a, b, s);
        endcase
    endfunction

    always_comb {G, E, L} = cmp_out({a2, a1, a0}, {b2, b1, b0}, S, fault);

    // Outcome of pair p: 0 = correct G, 1 = correct E, 2 = correct L, 3 = error.
    function automatic int classify(input int p, input logic s, input int flt);
        logic [2:0] a, b, obs, exp;
        a   = 3'(p >> 3);
        b   = 3'(p);
        obs = cmp_out(a, b, s, flt);
        exp = ref_gel(a, b, s);
        if (obs != exp) return 3;
        if (obs == 3'b100) return 0;
        if (obs == 3'b010) return 1;
        return 2;
    endfunction

    // Expected outputs t cycles after the start edge.
    function automatic logic [43:0] model_vec(input int t, input logic s, input int flt);
        int c, n0, n1, n2, n3, first, k;
        bit flag;
        logic [5:0] idx;
        c = t / (SETTLE + 1);
        if (c > 64) c = 64;
        n0 = 0; n1 = 0; n2 = 0; n3 = 0; first = 0; flag = 1'b0;
        for (int p = 0; p < c; p++) begin
            k = classify(p, s, flt);
            case (k)
                0: n0++;
                1: n1++;
                2: n2++;
                default: begin
                    n3++;
                    if (!flag) begin
                        flag  = 1'b1;
                        first = p;
                    end
                end
            endcase
        end
        idx = (c > 63) ? 6'd63 : 6'(c);
        return {(t < LAST_T), (t >= LAST_T), s, idx,
                7'(n0), 7'(n1), 7'(n2), 7'(n3), flag, 6'(first)};
    endfunction

    bit   m_active = 1'b0;
    int   m_t = 0;
    logic m_mode = 1'b0;
    int   m_fault = FLT_NONE;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active <= 1'b0;
            m_t      <= 0;
        end else if (start && !(m_active && m_t < LAST_T)) begin
            m_active <= 1'b1;
            m_t      <= 0;
            m_mode   <= mode;
            m_fault  <= fault;
        end else if (m_active && m_t < LAST_T) begin
            m_t <= m_t + 1;
        end
    end

    logic [43:0] act_vec;
    assign act_vec = {busy, done, S, a2, a1, a0, b2, b1, b0,
                      gt_cnt, eq_cnt, lt_cnt, err_cnt, err_flag, first_err_idx};

    always @(negedge clk) begin
        logic [43:0] exp_vec;
        if (rst || !m_active) exp_vec = '0;
        else exp_vec = model_vec(m_t, m_mode, m_fault);
        check("cycle_outputs", 64'(act_vec), 64'(exp_vec));
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_counts(input string tag, input int gt, input int eq, input int lt,
                                input int err, input int flag, input int first);
        check({tag, "_gt"}, 64'(gt_cnt), 64'(gt));
        check({tag, "_eq"}, 64'(eq_cnt), 64'(eq));
        check({tag, "_lt"}, 64'(lt_cnt), 64'(lt));
        check({tag, "_err"}, 64'(err_cnt), 64'(err));
        check({tag, "_flag"}, 64'(err_flag), 64'(flag));
        check({tag, "_first"}, 64'(first_err_idx), 64'(first));
        check({tag, "_sum"}, 64'(int'(gt_cnt) + int'(eq_cnt) + int'(lt_cnt) + int'(err_cnt)), 64'(64));
    endtask

    // Start a sweep and wait (bounded) for done; cycles counts edges from the start edge.
    task automatic run_sweep(input string tag, input int restart_at, input int flip_at,
                             input bit probe, output int cycles);
        pulse_start();
        check({tag, "_start_state"},
              64'({busy, done, gt_cnt, eq_cnt, lt_cnt, err_cnt, err_flag}),
              64'({1'b1, 1'b0, 7'd0, 7'd0, 7'd0, 7'd0, 1'b0}));
        cycles = 0;
        while (!done && cycles < 400) begin
            start = (cycles == restart_at);
            if (cycles == flip_at) mode = ~mode;
            if (probe && cycles == 58) begin
                check("probe_idx29_ops", 64'({a2, a1, a0, b2, b1, b0}), 64'(6'b011_101));
                check("probe_idx29_gel", 64'({S, G, E, L}), 64'(4'b1100));
            end
            @(negedge clk);
            cycles++;
        end
        start = 1'b0;
        check({tag, "_cycles"}, 64'(cycles), 64'(LAST_T));
    endtask

    initial begin
        int cyc;
        repeat (2) @(negedge clk);
        check("reset_outputs", 64'(act_vec), 64'(0));
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_outputs", 64'(act_vec), 64'(0));

        mode = 1'b0; fault = FLT_NONE;
        run_sweep("unsigned", -1, -1, 1'b0, cyc);
        check_counts("unsigned", 28, 8, 28, 0, 0, 0);

        mode = 1'b1; fault = FLT_NONE;
        run_sweep("signed", -1, 10, 1'b1, cyc);
        check_counts("signed", 28, 8, 28, 0, 0, 0);
        check("signed_S_held", 64'(S), 64'(1));

        mode = 1'b1; fault = FLT_IGNORE_S;
        run_sweep("ignore_s", -1, -1, 1'b0, cyc);
        check_counts("ignore_s", 12, 8, 12, 32, 1, 4);

        mode = 1'b0; fault = FLT_GE_STUCK;
        run_sweep("ge_stuck", -1, -1, 1'b0, cyc);
        check_counts("ge_stuck", 0, 0, 0, 64, 1, 0);

        mode = 1'b0; fault = FLT_NONE;
        pulse_start();
        repeat (50) @(negedge clk);
        #2 rst = 1'b1;
        #1 check("async_reset_outputs", 64'(act_vec), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        run_sweep("after_reset", -1, -1, 1'b0, cyc);
        check_counts("after_reset", 28, 8, 28, 0, 0, 0);

        mode = 1'b1; fault = FLT_IGNORE_S;
        run_sweep("busy_start", 20, -1, 1'b0, cyc);
        check_counts("busy_start", 12, 8, 12, 32, 1, 4);
        fault = FLT_NONE;
        run_sweep("done_restart", -1, -1, 1'b0, cyc);
        check_counts("done_restart", 28, 8, 28, 0, 0, 0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
